systolic_ctrl_nxn: RTL and testbench
====================================

// Module: systolic_ctrl_nxn
// PURPOSE
//  Parametrised control unit for an N x N output-stationary systolic MAC array.
//  Replaces the fixed 2x2 sequencer and adds the following:
//   - start/busy/done handshake and a runtime inner dimension k_len.
//   - per-PE accumulator clears that follow the skewed wavefront.
//   - row-major result drain under valid/ready backpressure.
//  Sits between the operand feeders (driven by feed_en/feed_k) and the PE grid/result mux.
// PARAMETERS
//  N       2   array dimension (N x N PEs), N >= 1
//  K_MAX   8   maximum inner dimension accepted
//  KW      4   width of k_len/feed_k, >= clog2(K_MAX+1)
//  IW      1   width of out_row/out_col, >= max(1, clog2(N))
//  TW      5   width of cycle counter t, holds K_MAX+2N-2
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset (0 = reset)
//  start      in   1      request; sampled only in IDLE
//  k_len      in   KW     inner dimension, sampled with start
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle completion pulse
//  feed_en    out  1      feeders present operand column/row feed_k this cycle
//  feed_k     out  KW     operand index 0..K-1 (0 when feed_en low)
//  clear      out  N*N    bit r*N+c: PE(r,c) loads product instead of accumulating
//  out_valid  out  1      result select (out_row, out_col) valid
//  out_row    out  IW     result row index
//  out_col    out  IW     result column index
//  out_ready  in   1      downstream accepts result beat
//  abort      in   1      only present with SYSTOLIC_ABORT_EN
// BEHAVIOUR
//  - Reset: state=IDLE; t, K, drain counters=0; every output 0.
//  - States: IDLE -> LOAD -> FEED -> FLUSH -> DRAIN -> DONE -> IDLE.
//  - IDLE: start=1 latches K = min(k_len, K_MAX), then goes to LOAD. start in any other state is ignored.
//  - LOAD: one cycle, t=0. If K==0, go to DONE (no feed, no clear, no drain). Otherwise go to FEED.
//  - FEED: t = 0..K-1, one per cycle. feed_en=1, feed_k=t.
//  - FLUSH: t = K..K+2N-3 (2N-2 cycles), lets the skew and the 1-cycle MAC settle. Skipped when N==1.
//  - Clear wavefront: clear[r*N+c] = (FEED or FLUSH) and t == r+c. Exactly one pulse per PE per job.
//  - DRAIN: out_valid=1 with (out_row,out_col) in row-major order (0,0),(0,1),...,(N-1,N-1).
//     - A beat advances only on out_valid & out_ready.
//     - Indices are held stable while out_ready=0.
//     - The last accepted beat goes to DONE.
//  - DONE: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle the state returns to IDLE.
//  - Latency, start sampled to first out_valid, for K>0: 1 + K + (2N-2) cycles.
//  - Outputs are Moore-decoded from state and counters. No output depends combinationally on any input.
//  - Reset asserted mid-job: immediate return to reset values. No done. A partial drain is discarded.
// CONFIGURATION
//  SYSTOLIC_ABORT_EN defined:
//   - Adds the abort input.
//   - abort=1 in any non-IDLE state: the next state is IDLE, and clear = all ones for that one cycle.
//   - No done pulse, out_valid drops.
//   - abort in IDLE has no effect.
//   - abort and start together in IDLE: start wins.
//  SYSTOLIC_ABORT_EN undefined: no abort port. A job always runs to DONE unless reset.
// STRUCTURE
//  - Package systolic_pkg:
//     - state encodings (IDLE=0, LOAD=1, FEED=2, FLUSH=3, DRAIN=4, DONE=5; 3-bit).
//     - default N, K_MAX, data width.
//     - a clog2 constant function.
//  - Sub-module systolic_drain_seq:
//     - row/col counter with valid/ready advance.
//     - ports: start_pulse, out_ready -> out_valid, out_row, out_col, last_beat.
//  - Top: FSM, t counter, clear decode.
// TESTING (N=2, K_MAX=8 unless noted)
//  1. Reset low, random inputs -> all outputs 0. Release: IDLE, busy=0.
//  2. start, k_len=3, out_ready=1 ->
//     - feed_k 0,1,2 on feed_en.
//     - clear[0] at t0; clear[1], clear[2] at t1; clear[3] at t2.
//     - 2 FLUSH cycles.
//     - beats (0,0),(0,1),(1,0),(1,1), then done for 1 cycle.
//  3. As 2 with out_ready=0 for 3 cycles at beat (0,1) -> indices hold (0,1), out_valid stays 1. Total job 3 cycles longer.
//  4. k_len=0 -> done 2 cycles after start is sampled; feed_en, clear, out_valid never assert.
//     k_len=12 -> exactly 8 feed cycles.
//  5. start pulsed during FEED and DRAIN -> ignored, job unchanged.
//     N=1, k_len=2 -> no FLUSH, single beat (0,0).
//  6. Reset low mid-DRAIN -> outputs 0 next cycle, no done.
//     With SYSTOLIC_ABORT_EN: abort in FEED -> clear=4'b1111 for one cycle, IDLE, no done.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the N x N systolic control unit: FSM encodings,
// default geometry and a constant clog2 used to size index fields.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int N_DEF     = 2;
  localparam int K_MAX_DEF = 8;
  localparam int DATA_W    = 16;
  localparam int KW_DEF    = clog2(K_MAX_DEF + 1);
  localparam int IW_DEF    = (clog2(N_DEF) < 1) ? 1 : clog2(N_DEF);
  // Must hold the last FLUSH index K_MAX+2N-3 plus the one-past value.
  localparam int TW_DEF    = 5;

endpackage

// File: rtl/systolic_ctrl_nxn_if.sv
// Handshake/control bundle between a job host and systolic_ctrl_nxn.
// The abort wire exists only when SYSTOLIC_ABORT_EN is defined.
interface systolic_ctrl_nxn_if #(
  parameter int N  = 2,
  parameter int KW = 4,
  parameter int IW = 1
) ();

  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic            feed_en;
  logic [KW-1:0]   feed_k;
  logic [N*N-1:0]  clear;
  logic            out_valid;
  logic [IW-1:0]   out_row;
  logic [IW-1:0]   out_col;
  logic            out_ready;
`ifdef SYSTOLIC_ABORT_EN
  logic            abort;
`endif

  modport master (
`ifdef SYSTOLIC_ABORT_EN
    output abort,
`endif
    output start, k_len, out_ready,
    input  busy, done, feed_en, feed_k, clear, out_valid, out_row, out_col
  );

  modport slave (
`ifdef SYSTOLIC_ABORT_EN
    input  abort,
`endif
    input  start, k_len, out_ready,
    output busy, done, feed_en, feed_k, clear, out_valid, out_row, out_col
  );

endinterface

// File: rtl/systolic_drain_seq.sv
// Row-major result index walker for the N x N grid; one beat advances per
// accepted valid/ready handshake, cancel kills an in-progress drain.
module systolic_drain_seq #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_pulse,
  input  logic          cancel,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [IW-1:0] out_row,
  output logic [IW-1:0] out_col,
  output logic          last_beat
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  assign last_beat = out_valid && (out_row == LAST_IDX) && (out_col == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (cancel) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (start_pulse) begin
      out_valid <= 1'b1;
      out_row   <= '0;
      out_col   <= '0;
    end else if (out_valid && out_ready) begin
      if (last_beat) begin
        out_valid <= 1'b0;
      end else if (out_col == LAST_IDX) begin
        out_col <= '0;
        out_row <= out_row + IW'(1);
      end else begin
        out_col <= out_col + IW'(1);
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl_nxn.sv
// Control unit for an N x N output-stationary systolic MAC array: job FSM,
// skewed clear wavefront and result drain. Optional abort: SYSTOLIC_ABORT_EN.
module systolic_ctrl_nxn
  import systolic_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int K_MAX = K_MAX_DEF,
  parameter int KW    = KW_DEF,
  parameter int IW    = IW_DEF,
  parameter int TW    = TW_DEF
) (
  input logic              clk,
  input logic              reset,
  systolic_ctrl_nxn_if.slave bus
);

  localparam int FLUSH_LEN = 2 * N - 2;

  state_t          state;
  state_t          state_next;
  logic [TW-1:0]   t;
  logic [KW-1:0]   k_reg;
  logic            abort_hit;
  logic            abort_clr;
  logic            last_feed;
  logic            last_flush;
  logic            enter_drain;
  logic            drain_valid;
  logic            last_beat;
  logic [IW-1:0]   drain_row;
  logic [IW-1:0]   drain_col;
  logic [N*N-1:0]  wave;

`ifdef SYSTOLIC_ABORT_EN
  assign abort_hit = bus.abort && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign last_feed   = (t == (TW'(k_reg) - TW'(1)));
  assign last_flush  = (t == (TW'(k_reg) + TW'(FLUSH_LEN - 1)));
  assign enter_drain = (state_next == ST_DRAIN) && (state != ST_DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (bus.start) state_next = ST_LOAD;
      ST_LOAD:  state_next = (k_reg == '0) ? ST_DONE : ST_FEED;
      ST_FEED:  if (last_feed) state_next = (N == 1) ? ST_DRAIN : ST_FLUSH;
      ST_FLUSH: if (last_flush) state_next = ST_DRAIN;
      ST_DRAIN: if (last_beat && bus.out_ready) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort_hit) state_next = ST_IDLE;
  end

  // t runs continuously through FEED and FLUSH so the wavefront decode is a
  // plain compare against r+c; every other state parks it at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t         <= '0;
      k_reg     <= '0;
      abort_clr <= 1'b0;
    end else begin
      abort_clr <= abort_hit;
      if ((state == ST_FEED || state == ST_FLUSH) && !abort_hit) t <= t + TW'(1);
      else                                                      t <= '0;
      if (state == ST_IDLE && bus.start)
        k_reg <= (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign wave[r*N+c] = (t == TW'(r + c));
    end
  end

  systolic_drain_seq #(
    .N  (N),
    .IW (IW)
  ) u_drain (
    .clk         (clk),
    .reset       (reset),
    .start_pulse (enter_drain),
    .cancel      (abort_hit),
    .out_ready   (bus.out_ready),
    .out_valid   (drain_valid),
    .out_row     (drain_row),
    .out_col     (drain_col),
    .last_beat   (last_beat)
  );

  // An abort leaves partial sums behind, so the cycle after it clears every PE.
  assign bus.clear     = abort_clr ? '1
                       : ((state == ST_FEED || state == ST_FLUSH) ? wave : '0);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.feed_en   = (state == ST_FEED);
  assign bus.feed_k    = (state == ST_FEED) ? KW'(t) : '0;
  assign bus.out_valid = drain_valid;
  assign bus.out_row   = drain_valid ? drain_row : '0;
  assign bus.out_col   = drain_valid ? drain_col : '0;

endmodule

// File: tb/tb_systolic_ctrl_nxn.sv
// Directed self-checking bench for systolic_ctrl_nxn (N=2 and N=1 instances);
// the abort scenario is compiled in with SYSTOLIC_ABORT_EN.
module tb_systolic_ctrl_nxn;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  // Per-cycle trace {busy,done,feed_en,feed_k,clear,out_valid,out_row,out_col}
  // of an N=2, K=3 job with out_ready held high, cycle 1 = first after start.
  logic [13:0] exp_job [1:12];

  systolic_ctrl_nxn_if #(.N(2), .KW(4), .IW(1)) bus2 ();
  systolic_ctrl_nxn_if #(.N(1), .KW(4), .IW(1)) bus1 ();

  systolic_ctrl_nxn #(.N(2), .K_MAX(8), .KW(4), .IW(1), .TW(5)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  systolic_ctrl_nxn #(.N(1), .K_MAX(8), .KW(4), .IW(1), .TW(5)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [13:0] obs2;
    logic [10:0] obs1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus2.start     = 1'($urandom);
      bus2.k_len     = 4'($urandom);
      bus2.out_ready = 1'($urandom);
      bus1.start     = 1'($urandom);
      bus1.k_len     = 4'($urandom);
      bus1.out_ready = 1'($urandom);
      tick;
      obs2 = {bus2.busy, bus2.done, bus2.feed_en, bus2.feed_k, bus2.clear,
              bus2.out_valid, bus2.out_row, bus2.out_col};
      obs1 = {bus1.busy, bus1.done, bus1.feed_en, bus1.feed_k, bus1.clear,
              bus1.out_valid, bus1.out_row, bus1.out_col};
      n_cmp++;
      if (obs2 !== 14'd0) begin
        n_bad++;
        $display("[TB] FAIL reset_outputs_n2 cycle %0d: got %b expected 0", i, obs2);
      end
      n_cmp++;
      if (obs1 !== 11'd0) begin
        n_bad++;
        $display("[TB] FAIL reset_outputs_n1 cycle %0d: got %b expected 0", i, obs1);
      end
    end
    bus2.start = 1'b0; bus2.k_len = '0; bus2.out_ready = 1'b1;
    bus1.start = 1'b0; bus1.k_len = '0; bus1.out_ready = 1'b1;
    reset = 1'b1;
    tick;
    obs2 = {bus2.busy, bus2.done, bus2.feed_en, bus2.feed_k, bus2.clear,
            bus2.out_valid, bus2.out_row, bus2.out_col};
    n_cmp++;
    if (obs2 !== 14'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_release_idle: got %b expected 0", obs2);
    end
  endtask

  task automatic test_basic_job;
    logic [13:0] obs;
    bus2.k_len = 4'd3; bus2.out_ready = 1'b1; bus2.start = 1'b1;
    tick;
    bus2.start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      obs = {bus2.busy, bus2.done, bus2.feed_en, bus2.feed_k, bus2.clear,
             bus2.out_valid, bus2.out_row, bus2.out_col};
      n_cmp++;
      if (obs !== exp_job[c]) begin
        n_bad++;
        $display("[TB] FAIL basic_job cycle %0d: got %b expected %b", c, obs, exp_job[c]);
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    logic [13:0] obs;
    logic [13:0] expv;
    bus2.k_len = 4'd3; bus2.out_ready = 1'b1; bus2.start = 1'b1;
    tick;
    bus2.start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c <= 8)       expv = exp_job[c];
      else if (c <= 11) expv = exp_job[8];
      else              expv = exp_job[c-3];
      obs = {bus2.busy, bus2.done, bus2.feed_en, bus2.feed_k, bus2.clear,
             bus2.out_valid, bus2.out_row, bus2.out_col};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("[TB] FAIL backpressure cycle %0d: got %b expected %b", c, obs, expv);
      end
      bus2.out_ready = !(c >= 8 && c <= 10);
      tick;
    end
    bus2.out_ready = 1'b1;
  endtask

  task automatic test_zero_and_clamp;
    logic [13:0] obs;
    logic [13:0] exp_zero [1:3];
    int feeds;
    int last_k;
    int dones;
    exp_zero = '{14'b1_0_0_0000_0000_0_0_0,
                 14'b1_1_0_0000_0000_0_0_0,
                 14'b0_0_0_0000_0000_0_0_0};
    bus2.k_len = 4'd0; bus2.start = 1'b1;
    tick;
    bus2.start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      obs = {bus2.busy, bus2.done, bus2.feed_en, bus2.feed_k, bus2.clear,
             bus2.out_valid, bus2.out_row, bus2.out_col};
      n_cmp++;
      if (obs !== exp_zero[c]) begin
        n_bad++;
        $display("[TB] FAIL zero_k cycle %0d: got %b expected %b", c, obs, exp_zero[c]);
      end
      tick;
    end
    feeds = 0; last_k = -1; dones = 0;
    bus2.k_len = 4'd12; bus2.start = 1'b1;
    tick;
    bus2.start = 1'b0;
    for (int c = 1; c <= 40 && dones == 0; c++) begin
      if (bus2.feed_en) begin
        feeds++;
        last_k = int'(bus2.feed_k);
      end
      if (bus2.done) dones++;
      tick;
    end
    n_cmp++;
    if (feeds !== 8) begin
      n_bad++;
      $display("[TB] FAIL clamp_feed_count: got %0d expected 8", feeds);
    end
    n_cmp++;
    if (last_k !== 7) begin
      n_bad++;
      $display("[TB] FAIL clamp_last_feed_k: got %0d expected 7", last_k);
    end
    n_cmp++;
    if (dones !== 1) begin
      n_bad++;
      $display("[TB] FAIL clamp_done_within_40: got %0d expected 1", dones);
    end
    tick;
  endtask

  task automatic test_start_ignored;
    logic [13:0] obs;
    bus2.k_len = 4'd3; bus2.out_ready = 1'b1; bus2.start = 1'b1;
    tick;
    bus2.start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      obs = {bus2.busy, bus2.done, bus2.feed_en, bus2.feed_k, bus2.clear,
             bus2.out_valid, bus2.out_row, bus2.out_col};
      n_cmp++;
      if (obs !== exp_job[c]) begin
        n_bad++;
        $display("[TB] FAIL start_ignored cycle %0d: got %b expected %b", c, obs, exp_job[c]);
      end
      bus2.start = (c == 3 || c == 8);
      bus2.k_len = (c == 3 || c == 8) ? 4'd5 : 4'd3;
      tick;
    end
    bus2.start = 1'b0;
  endtask

  task automatic test_single_pe;
    logic [10:0] obs;
    logic [10:0] exp_one [1:6];
    exp_one = '{11'b1_0_0_0000_0_0_0_0,
                11'b1_0_1_0000_1_0_0_0,
                11'b1_0_1_0001_0_0_0_0,
                11'b1_0_0_0000_0_1_0_0,
                11'b1_1_0_0000_0_0_0_0,
                11'b0_0_0_0000_0_0_0_0};
    bus1.k_len = 4'd2; bus1.out_ready = 1'b1; bus1.start = 1'b1;
    tick;
    bus1.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      obs = {bus1.busy, bus1.done, bus1.feed_en, bus1.feed_k, bus1.clear,
             bus1.out_valid, bus1.out_row, bus1.out_col};
      n_cmp++;
      if (obs !== exp_one[c]) begin
        n_bad++;
        $display("[TB] FAIL single_pe cycle %0d: got %b expected %b", c, obs, exp_one[c]);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid_drain;
    logic [13:0] obs;
    bus2.k_len = 4'd1; bus2.out_ready = 1'b1; bus2.start = 1'b1;
    tick;
    bus2.start = 1'b0;
    for (int c = 1; c < 6; c++) tick;
    obs = {bus2.busy, bus2.done, bus2.feed_en, bus2.feed_k, bus2.clear,
           bus2.out_valid, bus2.out_row, bus2.out_col};
    n_cmp++;
    if (obs !== 14'b1_0_0_0000_0000_1_0_1) begin
      n_bad++;
      $display("[TB] FAIL mid_drain_beat: got %b expected %b", obs, 14'b1_0_0_0000_0000_1_0_1);
    end
    reset = 1'b0;
    tick;
    obs = {bus2.busy, bus2.done, bus2.feed_en, bus2.feed_k, bus2.clear,
           bus2.out_valid, bus2.out_row, bus2.out_col};
    n_cmp++;
    if (obs !== 14'd0) begin
      n_bad++;
      $display("[TB] FAIL mid_drain_reset: got %b expected 0", obs);
    end
    reset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      obs = {bus2.busy, bus2.done, bus2.feed_en, bus2.feed_k, bus2.clear,
             bus2.out_valid, bus2.out_row, bus2.out_col};
      n_cmp++;
      if (obs !== 14'd0) begin
        n_bad++;
        $display("[TB] FAIL after_reset_quiet cycle %0d: got %b expected 0", c, obs);
      end
    end
  endtask

`ifdef SYSTOLIC_ABORT_EN
  task automatic test_abort;
    logic [13:0] obs;
    logic [13:0] expv;
    bus2.k_len = 4'd3; bus2.out_ready = 1'b1; bus2.abort = 1'b0; bus2.start = 1'b1;
    tick;
    bus2.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c <= 3)      expv = exp_job[c];
      else if (c == 4) expv = 14'b0_0_0_0000_1111_0_0_0;
      else             expv = 14'd0;
      obs = {bus2.busy, bus2.done, bus2.feed_en, bus2.feed_k, bus2.clear,
             bus2.out_valid, bus2.out_row, bus2.out_col};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("[TB] FAIL abort cycle %0d: got %b expected %b", c, obs, expv);
      end
      bus2.abort = (c == 3 || c == 6);
      tick;
    end
    bus2.abort = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_job = '{14'b1_0_0_0000_0000_0_0_0,
                14'b1_0_1_0000_0001_0_0_0,
                14'b1_0_1_0001_0110_0_0_0,
                14'b1_0_1_0010_1000_0_0_0,
                14'b1_0_0_0000_0000_0_0_0,
                14'b1_0_0_0000_0000_0_0_0,
                14'b1_0_0_0000_0000_1_0_0,
                14'b1_0_0_0000_0000_1_0_1,
                14'b1_0_0_0000_0000_1_1_0,
                14'b1_0_0_0000_0000_1_1_1,
                14'b1_1_0_0000_0000_0_0_0,
                14'b0_0_0_0000_0000_0_0_0};
    reset = 1'b0;
    bus2.start = 1'b0; bus2.k_len = '0; bus2.out_ready = 1'b1;
    bus1.start = 1'b0; bus1.k_len = '0; bus1.out_ready = 1'b1;
`ifdef SYSTOLIC_ABORT_EN
    bus2.abort = 1'b0;
    bus1.abort = 1'b0;
`endif
    test_reset;
    test_basic_job;
    test_backpressure;
    test_zero_and_clamp;
    test_start_ignored;
    test_single_pe;
    test_reset_mid_drain;
`ifdef SYSTOLIC_ABORT_EN
    test_abort;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
